// File: rtl/rotl32_arbiter.sv
// rotl32_arbiter: shares one 32-bit rotate-left datapath between two requesters.
// Round-robin arbitration in IDLE, one operation in flight at a time, and the
// result is returned with the owning requester's ID.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   reqK_valid_i / reqK_ready_o   request handshake for requester K (0, 1)
//   reqK_data_i, reqK_amt_i       operand and rotate-left amount for requester K
//   res_valid_o / res_ready_i     result handshake
//   res_data_o, res_id_o          rotated result and owning requester ID
module rotl32_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AMT_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req0_valid_i,
    output logic              req0_ready_o,
    input  logic [DATA_W-1:0] req0_data_i,
    input  logic [AMT_W-1:0]  req0_amt_i,
    input  logic              req1_valid_i,
    output logic              req1_ready_o,
    input  logic [DATA_W-1:0] req1_data_i,
    input  logic [AMT_W-1:0]  req1_amt_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              res_id_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              prio_q;
    logic [DATA_W-1:0] op_data_q;
    logic [AMT_W-1:0]  op_amt_q;
    logic              op_id_q;

    logic              grant_any_c;
    logic              grant_id_c;
    logic              accept_c;
    logic              load_res_c;
    logic              consume_c;
    logic [DATA_W-1:0] rot_c;

    // Grant: a lone valid wins; on a tie the priority pointer decides.
    always_comb begin
        grant_any_c = req0_valid_i | req1_valid_i;
        grant_id_c  = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;
    end

    assign req0_ready_o = (state_q == IDLE) && grant_any_c && !grant_id_c;
    assign req1_ready_o = (state_q == IDLE) && grant_any_c &&  grant_id_c;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d    = state_q;
        accept_c   = 1'b0;
        load_res_c = 1'b0;
        consume_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any_c) begin
                    accept_c = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                load_res_c = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (res_ready_i) begin
                    consume_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture on the accepting edge only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_data_q <= '0;
            op_amt_q  <= '0;
            op_id_q   <= 1'b0;
        end else if (accept_c) begin
            op_data_q <= grant_id_c ? req1_data_i : req0_data_i;
            op_amt_q  <= grant_id_c ? req1_amt_i  : req0_amt_i;
            op_id_q   <= grant_id_c;
        end
    end

    // Five-level 2:1 mux rotator, largest step first
    always_comb begin
        logic [DATA_W-1:0] s16;
        logic [DATA_W-1:0] s8;
        logic [DATA_W-1:0] s4;
        logic [DATA_W-1:0] s2;
        s16   = op_amt_q[4] ? {op_data_q[DATA_W-17:0], op_data_q[DATA_W-1:DATA_W-16]} : op_data_q;
        s8    = op_amt_q[3] ? {s16[DATA_W-9:0], s16[DATA_W-1:DATA_W-8]} : s16;
        s4    = op_amt_q[2] ? {s8[DATA_W-5:0],  s8[DATA_W-1:DATA_W-4]}  : s8;
        s2    = op_amt_q[1] ? {s4[DATA_W-3:0],  s4[DATA_W-1:DATA_W-2]}  : s4;
        rot_c = op_amt_q[0] ? {s2[DATA_W-2:0],  s2[DATA_W-1]}           : s2;
    end

    // Result registers; data and ID hold while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_id_o    <= 1'b0;
        end else if (load_res_c) begin
            res_valid_o <= 1'b1;
            res_data_o  <= rot_c;
            res_id_o    <= op_id_q;
        end else if (consume_c) begin
            res_valid_o <= 1'b0;
        end
    end

    // Hand priority to the requester that was not just served
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (consume_c) begin
            prio_q <= ~res_id_o;
        end
    end

endmodule

// File: tb/tb_rotl32_arbiter.sv
// Self-checking bench for rotl32_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a rule-level model.
module tb_rotl32_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req0_valid_i, req1_valid_i;
    logic        req0_ready_o, req1_ready_o;
    logic [31:0] req0_data_i, req1_data_i;
    logic [4:0]  req0_amt_i, req1_amt_i;
    logic        res_valid_o, res_ready_i;
    logic [31:0] res_data_o;
    logic        res_id_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    rotl32_arbiter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req0_valid_i (req0_valid_i),
        .req0_ready_o (req0_ready_o),
        .req0_data_i  (req0_data_i),
        .req0_amt_i   (req0_amt_i),
        .req1_valid_i (req1_valid_i),
        .req1_ready_o (req1_ready_o),
        .req1_data_i  (req1_data_i),
        .req1_amt_i   (req1_amt_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_id_o     (res_id_o)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Rotate-left as a window into the operand concatenated with itself
    function automatic logic [31:0] rotl_ref(input logic [31:0] d, input int a);
        logic [63:0] w;
        w = {d, d} << a;
        return w[63:32];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #3;
        step();
        rst_ni = 1'b1;
    endtask

    // One isolated operation: accept, check latency, consume immediately
    task automatic do_op(input vec_t v);
        res_ready_i = 1'b1;
        if (v.id) begin
            req1_valid_i = 1'b1; req1_data_i = v.data; req1_amt_i = v.amt;
        end else begin
            req0_valid_i = 1'b1; req0_data_i = v.data; req0_amt_i = v.amt;
        end
        @(negedge clk_i);
        check("op_ready", 32'({req1_ready_o, req0_ready_o}), v.id ? 32'd2 : 32'd1);
        step();
        // Operand isolation: scramble inputs right after acceptance
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_data_i = ~req0_data_i; req1_data_i = ~req1_data_i;
        req0_amt_i = req0_amt_i + 5'd3; req1_amt_i = req1_amt_i + 5'd7;
        @(negedge clk_i);
        check("op_busy_valid", 32'(res_valid_o), 32'd0);
        step();
        @(negedge clk_i);
        check("op_res_valid", 32'(res_valid_o), 32'd1);
        check("op_res_data", res_data_o, v.exp);
        check("op_res_id", 32'(res_id_o), 32'(v.id));
        check("op_done_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
        step();
    endtask

    logic        pending;
    int          age;
    logic        exp_id;
    logic [31:0] exp_data;
    logic        prio_m;

    initial begin
        tbl[0] = '{1'b0, 32'hF0F0F0F0, 5'd4,  32'h0F0F0F0F};
        tbl[1] = '{1'b0, 32'hF0F0F0F0, 5'd1,  32'hE1E1E1E1};
        tbl[2] = '{1'b1, 32'h80000001, 5'd31, 32'hC0000000};
        tbl[3] = '{1'b0, 32'h12345678, 5'd16, 32'h56781234};
        tbl[4] = '{1'b1, 32'h12345678, 5'd0,  32'h12345678};
        tbl[5] = '{1'b0, 32'hA5A5A5A5, 5'd1,  32'h4B4B4B4B};
        tbl[6] = '{1'b1, 32'h00000001, 5'd8,  32'h00000100};

        rst_ni = 1'b0;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        req0_data_i = '0; req1_data_i = '0; req0_amt_i = '0; req1_amt_i = '0;
        res_ready_i = 1'b1;
        #12;
        check("rst_valid", 32'(res_valid_o), 32'd0);
        check("rst_data", res_data_o, 32'd0);
        check("rst_id", 32'(res_id_o), 32'd0);
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
        step();

        // Directed vector table
        for (int i = 0; i < 7; i++) do_op(tbl[i]);

        // Backpressure: result holds, readies stay low, next accept one cycle after ready
        res_ready_i = 1'b0;
        req0_valid_i = 1'b1; req0_data_i = 32'h0000FFFF; req0_amt_i = 5'd8;
        step();
        req0_data_i = 32'h00000003; req0_amt_i = 5'd2;
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("bp_valid", 32'(res_valid_o), 32'd1);
            check("bp_data", res_data_o, 32'h00FFFF00);
            check("bp_id", 32'(res_id_o), 32'd0);
            check("bp_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
            step();
        end
        res_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_rise_ready", 32'(req0_ready_o), 32'd0);
        step();
        @(negedge clk_i);
        check("bp_next_ready", 32'(req0_ready_o), 32'd1);
        check("bp_next_valid", 32'(res_valid_o), 32'd0);
        step();
        req0_valid_i = 1'b0;
        step();
        @(negedge clk_i);
        check("bp_second_data", res_data_o, 32'h0000000C);
        step();

        // Reset asserted mid-DONE drops the result at once
        res_ready_i = 1'b0;
        req1_valid_i = 1'b1; req1_data_i = 32'hDEADBEEF; req1_amt_i = 5'd4;
        step();
        req1_valid_i = 1'b0;
        step();
        @(negedge clk_i);
        check("mid_done_valid", 32'(res_valid_o), 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 32'(res_valid_o), 32'd0);
        check("async_rst_data", res_data_o, 32'd0);
        check("async_rst_id", 32'(res_id_o), 32'd0);
        step();
        rst_ni = 1'b1;
        res_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("post_rst_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
            check("post_rst_valid", 32'(res_valid_o), 32'd0);
            step();
        end

        // Round-robin with both requesters continuously valid
        begin
            logic        exp_ids [4];
            logic [31:0] exp_dat [4];
            int          n;
            exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
            exp_dat = '{32'h4B4B4B4B, 32'h00000100, 32'h4B4B4B4B, 32'h00000100};
            n = 0;
            req0_valid_i = 1'b1; req0_data_i = 32'hA5A5A5A5; req0_amt_i = 5'd1;
            req1_valid_i = 1'b1; req1_data_i = 32'h00000001; req1_amt_i = 5'd8;
            for (int c = 0; c < 40 && n < 4; c++) begin
                @(negedge clk_i);
                check("rr_one_ready", 32'(req0_ready_o & req1_ready_o), 32'd0);
                if (res_valid_o) begin
                    check("rr_id", 32'(res_id_o), 32'(exp_ids[n]));
                    check("rr_data", res_data_o, exp_dat[n]);
                    n++;
                end
                step();
            end
            check("rr_results_seen", 32'(n), 32'd4);
            req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        end

        // Random traffic against the rule-level model
        do_reset();
        pending = 1'b0; age = 0; exp_id = 1'b0; exp_data = '0; prio_m = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            logic acc0, acc1, cons, any, win;
            logic [31:0] d0, d1;
            logic [4:0]  a0, a1;
            @(negedge clk_i);
            check("rnd_one_ready", 32'(req0_ready_o & req1_ready_o), 32'd0);
            if (pending) begin
                check("rnd_busy_ready", 32'({req1_ready_o, req0_ready_o}), 32'd0);
            end else begin
                any = req0_valid_i | req1_valid_i;
                win = (req0_valid_i & req1_valid_i) ? prio_m : req1_valid_i;
                check("rnd_grant", 32'({req1_ready_o, req0_ready_o}),
                      32'({any & win, any & ~win}));
            end
            check("rnd_valid", 32'(res_valid_o), 32'(pending && age >= 2));
            if (res_valid_o && pending && age >= 2) begin
                check("rnd_data", res_data_o, exp_data);
                check("rnd_id", 32'(res_id_o), 32'(exp_id));
            end
            acc0 = req0_valid_i & req0_ready_o;
            acc1 = req1_valid_i & req1_ready_o;
            cons = res_valid_o & res_ready_i;
            d0 = req0_data_i; d1 = req1_data_i; a0 = req0_amt_i; a1 = req1_amt_i;
            step();
            if (cons && pending && age >= 2) begin
                pending = 1'b0;
                prio_m  = ~exp_id;
            end else if (pending) begin
                age++;
            end
            if (acc0 || acc1) begin
                pending  = 1'b1;
                age      = 1;
                exp_id   = acc1;
                exp_data = acc1 ? rotl_ref(d1, int'(a1)) : rotl_ref(d0, int'(a0));
            end
            if (acc0 || !req0_valid_i) begin
                req0_valid_i = ($urandom_range(0, 2) != 0);
                req0_data_i  = $urandom();
                req0_amt_i   = 5'($urandom_range(0, 31));
            end
            if (acc1 || !req1_valid_i) begin
                req1_valid_i = ($urandom_range(0, 2) != 0);
                req1_data_i  = $urandom();
                req1_amt_i   = 5'($urandom_range(0, 31));
            end
            res_ready_i = ($urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
